// File: rtl/popcount_sequencer_if.sv
// Start/done handshake bundle between the control unit (master) and the
// popcount sequencer (slave).
interface popcount_sequencer_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;

    modport master (output start, output data_in, input busy, input done, input count);
    modport slave  (input start, input data_in, output busy, output done, output count);
endinterface

// File: rtl/popcount_sequencer.sv
// Multi-cycle population count: one nibble per cycle through a single 4-bit LUT.
// Optional macro POPCNT_EARLY_TERM_EN finishes as soon as the remaining operand bits are zero.
module lut_4 (
    input  logic [3:0] nib,
    output logic [2:0] cnt
);
    assign cnt = {2'b00, nib[0]} + {2'b00, nib[1]} + {2'b00, nib[2]} + {2'b00, nib[3]};
endmodule

// state | meaning
// IDLE  | waiting for start; count holds last result
// RUN   | one nibble counted per edge, LSB nibble first
// DONE  | one-cycle done pulse, then back to IDLE
module popcount_sequencer #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    popcount_sequencer_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("popcount_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    idx;
    logic [2:0]       lut_cnt;
    logic [CW-1:0]    sum;
    logic             last;

    lut_4 u_lut (
        .nib (sreg[3:0]),
        .cnt (lut_cnt)
    );

    assign sum = acc + CW'(lut_cnt);

    always_comb begin
        last = (idx == IW'(NIB - 1));
`ifdef POPCNT_EARLY_TERM_EN
        // Remaining nibbles all zero: the total cannot change any more.
        last = last || ((sreg >> 4) == '0);
`else
        last = last || 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            acc     <= '0;
            idx     <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg    <= bus.data_in;
                        acc     <= '0;
                        idx     <= '0;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    acc  <= sum;
                    sreg <= sreg >> 4;
                    idx  <= idx + IW'(1);
                    if (last) count_q <= sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.count = count_q;
endmodule

// File: tb/tb_popcount_sequencer.sv
// Scoreboard bench for popcount_sequencer (WIDTH=16): stimulus queues expected
// count and done cycle, an independent monitor checks every done pulse.
module tb_popcount_sequencer;
    localparam int WIDTH = 16;

    typedef struct {
        int exp_count;
        int exp_cycle;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    sb_t  sb[$];

    popcount_sequencer_if #(.WIDTH(WIDTH)) bus ();

    popcount_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] d);
        int l;
`ifdef POPCNT_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 4; i++)
            if (d[4*i +: 4] != 4'h0) l = i + 1;
`else
        l = 4;
`endif
        return l;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("count", int'(bus.count), e.exp_count);
                    check("done_cycle", cyc, e.exp_cycle);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(bus.busy || bus.done), 0);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", sb.size(), 0);
    endtask

    // Presents an operand at a negedge in IDLE; returns #1 after the capture edge.
    task automatic issue(input logic [15:0] d, input int exp_cnt, input bit push);
        sb_t e;
        wait_idle();
        bus.start   = 1'b1;
        bus.data_in = d;
        e.exp_count = exp_cnt;
        e.exp_cycle = cyc + 1 + exp_lat(d);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("count_clear", int'(bus.count), 0);
        check("busy_run", int'(bus.busy), 1);
    endtask

    initial begin
        int lat1;
        errors = 0;
        checks = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        #3;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_count", int'(bus.count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(16'h0000, 0, 1);
        wait_empty();

        issue(16'hFFFF, 16, 1);
        wait_empty();
        repeat (3) @(negedge clk);
        check("hold_ffff", int'(bus.count), 16);

        // start pulse during RUN must be ignored; count shows no partial sum
        issue(16'h8421, 4, 1);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.data_in = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("no_partial", int'(bus.count), 0);
        wait_empty();
        repeat (4) @(negedge clk);
        check("hold_8421", int'(bus.count), 4);
        check("idle_busy", int'(bus.busy), 0);

        issue(16'h00F3, 6, 1);
        wait_empty();

        // start held through RUN and DONE: second operand captured only back in IDLE
        begin
            sb_t e;
            wait_idle();
            lat1 = exp_lat(16'h0F0F);
            bus.start   = 1'b1;
            bus.data_in = 16'h0F0F;
            e.exp_count = 8;
            e.exp_cycle = cyc + 1 + lat1;
            sb.push_back(e);
            e.exp_count = 3;
            e.exp_cycle = cyc + 1 + lat1 + 2 + exp_lat(16'h7000);
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.data_in = 16'h7000;
            repeat (lat1 + 2) @(posedge clk);
            #1;
            bus.start = 1'b0;
            check("second_busy", int'(bus.busy), 1);
            wait_empty();
        end

        // operand change after capture has no effect
        issue(16'h0001, 1, 1);
        bus.data_in = 16'hFFFF;
        wait_empty();
        repeat (5) @(negedge clk);
        check("hold_0001", int'(bus.count), 1);

        // asynchronous reset mid-RUN abandons the operation
        issue(16'hFFFF, 16, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_count", int'(bus.count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_count", int'(bus.count), 0);
        check("post_rst_busy", int'(bus.busy), 0);

        issue(16'hFFFF, 16, 1);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
